// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction-decode stage between fetch and execute.
// Each accepted instruction is decoded into a control bundle. The bundle is held
// in a two-entry FIFO made of an output register and a skid register, so fetch can
// stream at full rate while execute applies backpressure. A synchronous flush
// empties both entries.
// Optional feature: define DECODE_RVM_EN to decode M-extension (funct7=0000001) ops.
module decode_stage #(
   parameter int PC_W    = 32,
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [4:0]         rd,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic               reg_wr,
   output logic               mem_wr,
   output logic               sel_A,
   output logic               sel_B,
   output logic [1:0]         wb_sel,
   output logic [2:0]         rd_wr_mem,
   output logic [2:0]         br_type,
   output logic [3:0]         alu_op,
   output logic [31:0]        immediate,
   output logic               illegal,
   output logic               md_en,
   output logic [2:0]         md_op,
   output logic [COUNT_W-1:0] dec_count
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [2:0] BR_NONE    = 3'b010;
   localparam logic [2:0] BR_JUMP    = 3'b011;

   localparam logic [1:0] WB_ALU     = 2'b00;
   localparam logic [1:0] WB_MEM     = 2'b01;
   localparam logic [1:0] WB_PC4     = 2'b10;
   localparam logic [1:0] WB_IMM     = 2'b11;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            reg_wr;
      logic            mem_wr;
      logic            sel_a;
      logic            sel_b;
      logic [1:0]      wb_sel;
      logic [2:0]      rd_wr_mem;
      logic [2:0]      br_type;
      logic [3:0]      alu_op;
      logic [31:0]     immediate;
      logic            illegal;
      logic            md_en;
      logic [2:0]      md_op;
   } bundle_t;

   // Idle bundle: everything zero, no branch.
   function automatic bundle_t rst_bundle();
      bundle_t b;
      b         = '0;
      b.br_type = BR_NONE;
      return b;
   endfunction

   // Full RV32I decode of one instruction word into a control bundle.
   function automatic bundle_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
      bundle_t           b;
      logic [6:0]        opc;
      logic [2:0]        f3;
      logic [6:0]        f7;
      logic signed [31:0] imm_i;
      logic signed [31:0] imm_s;
      logic signed [31:0] imm_b;
      logic signed [31:0] imm_j;
      logic signed [31:0] imm_u;

      opc   = instr[6:0];
      f3    = instr[14:12];
      f7    = instr[31:25];
      imm_i = {{20{instr[31]}}, instr[31:20]};
      imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      imm_u = {instr[31:12], 12'h000};

      b           = rst_bundle();
      b.pc        = pc;
      b.rd        = instr[11:7];
      b.rs1       = instr[19:15];
      b.rs2       = instr[24:20];
      b.rd_wr_mem = f3;

      case (opc)
         OPC_OP: begin
            b.alu_op = {f3, instr[30]};
            b.reg_wr = 1'b1;
            if (f7 == F7_ALT) begin
               // Only SUB and SRA have an alternate encoding.
               if (f3 != 3'b000 && f3 != 3'b101) b.illegal = 1'b1;
            end
`ifdef DECODE_RVM_EN
            else if (f7 == F7_MULDIV) begin
               b.md_en  = 1'b1;
               b.md_op  = f3;
               b.wb_sel = WB_ALU;
            end
`else
            else if (f7 == F7_MULDIV) begin
               b.illegal = 1'b1;
            end
`endif
            else if (f7 != F7_BASE) begin
               b.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            // bit30 selects SRAI vs SRLI; for every other funct3 it is immediate data.
            b.alu_op    = {f3, (f3 == 3'b101) ? instr[30] : 1'b0};
            b.reg_wr    = 1'b1;
            b.sel_b     = 1'b1;
            b.immediate = imm_i;
            if (f3 == 3'b001 && f7 != F7_BASE) b.illegal = 1'b1;
            if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) b.illegal = 1'b1;
         end
         OPC_LOAD: begin
            b.reg_wr    = 1'b1;
            b.sel_b     = 1'b1;
            b.wb_sel    = WB_MEM;
            b.immediate = imm_i;
         end
         OPC_STORE: begin
            b.mem_wr    = 1'b1;
            b.sel_b     = 1'b1;
            b.immediate = imm_s;
         end
         OPC_BRANCH: begin
            b.sel_a     = 1'b1;
            b.sel_b     = 1'b1;
            b.br_type   = f3;
            b.immediate = imm_b;
            if (f3 == 3'b010 || f3 == 3'b011) b.illegal = 1'b1;
         end
         OPC_JAL: begin
            b.reg_wr    = 1'b1;
            b.sel_a     = 1'b1;
            b.sel_b     = 1'b1;
            b.wb_sel    = WB_PC4;
            b.br_type   = BR_JUMP;
            b.immediate = imm_j;
         end
         OPC_JALR: begin
            b.reg_wr    = 1'b1;
            b.sel_b     = 1'b1;
            b.wb_sel    = WB_PC4;
            b.br_type   = BR_JUMP;
            b.immediate = imm_i;
         end
         OPC_LUI: begin
            b.reg_wr    = 1'b1;
            b.sel_b     = 1'b1;
            b.wb_sel    = WB_IMM;
            b.immediate = imm_u;
         end
         OPC_AUIPC: begin
            b.reg_wr    = 1'b1;
            b.sel_a     = 1'b1;
            b.sel_b     = 1'b1;
            b.wb_sel    = WB_ALU;
            b.immediate = imm_u;
         end
         default: begin
            b.illegal = 1'b1;
         end
      endcase

      // An illegal bundle still flows to execute but must have no side effects.
      if (b.illegal) begin
         b.reg_wr  = 1'b0;
         b.mem_wr  = 1'b0;
         b.br_type = BR_NONE;
         b.md_en   = 1'b0;
         b.md_op   = 3'b000;
      end
      return b;
   endfunction

   bundle_t            new_bndl_p0;
   bundle_t            out_bndl_p1;
   bundle_t            skid_bndl_p1;
   logic               vld_p1;
   logic               skid_vld_p1;
   logic [COUNT_W-1:0] count_p1;
   logic               in_fire;
   logic               out_fire;

   // ---- stage p0: decode the incoming word; flush cancels both transfers ----
   assign new_bndl_p0 = decode(in_instr, in_pc);
   assign in_fire     = in_valid & ~skid_vld_p1 & ~flush;
   assign out_fire    = vld_p1 & out_ready & ~flush;

   // Occupancy flags and output-transfer counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         count_p1    <= '0;
      end else if (flush) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else begin
         if (out_fire) begin
            count_p1    <= count_p1 + COUNT_W'(1);
            // Skid (if any) or the new bundle refills the output; skid always drains.
            vld_p1      <= skid_vld_p1 | in_fire;
            skid_vld_p1 <= 1'b0;
         end else begin
            vld_p1      <= vld_p1 | in_fire;
            skid_vld_p1 <= skid_vld_p1 | (vld_p1 & in_fire);
         end
      end
   end

   // Bundle storage: route the new bundle to output or skid, keeping FIFO order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_bndl_p1  <= rst_bundle();
         skid_bndl_p1 <= rst_bundle();
      end else if (!flush) begin
         if (out_fire) begin
            if (skid_vld_p1)  out_bndl_p1 <= skid_bndl_p1;
            else if (in_fire) out_bndl_p1 <= new_bndl_p0;
         end else if (in_fire) begin
            if (vld_p1) skid_bndl_p1 <= new_bndl_p0;
            else        out_bndl_p1  <= new_bndl_p0;
         end
      end
   end

   // ---- stage p1: present the output entry ----
   assign in_ready  = ~skid_vld_p1;
   assign out_valid = vld_p1;
   assign out_pc    = out_bndl_p1.pc;
   assign rd        = out_bndl_p1.rd;
   assign rs1       = out_bndl_p1.rs1;
   assign rs2       = out_bndl_p1.rs2;
   assign reg_wr    = out_bndl_p1.reg_wr;
   assign mem_wr    = out_bndl_p1.mem_wr;
   assign sel_A     = out_bndl_p1.sel_a;
   assign sel_B     = out_bndl_p1.sel_b;
   assign wb_sel    = out_bndl_p1.wb_sel;
   assign rd_wr_mem = out_bndl_p1.rd_wr_mem;
   assign br_type   = out_bndl_p1.br_type;
   assign alu_op    = out_bndl_p1.alu_op;
   assign immediate = out_bndl_p1.immediate;
   assign illegal   = out_bndl_p1.illegal;
   assign md_en     = out_bndl_p1.md_en;
   assign md_op     = out_bndl_p1.md_op;
   assign dec_count = count_p1;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I instruction-decode pipeline stage with valid/ready handshakes on both sides. It sits between fetch and execute in the pipelined core.
- Decodes the full RV32I base opcode set (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) into the control bundle used by the single-cycle datapath, plus register addresses, PC and an illegal-instruction flag.
- A 2-entry skid buffer lets fetch stream at full rate under execute backpressure, with a synchronous flush for branch redirect.

Parameters:
PC_W, 32, width of PC passthrough
COUNT_W, 32, width of decoded-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  drop all buffered entries
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  PC_W  PC of bundle
rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20]
reg_wr, mem_wr, sel_A, sel_B  out  1 each  regfile write, memory write, A=PC, B=imm
wb_sel  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
rd_wr_mem  out  3  funct3 passthrough (load/store size)
br_type  out  3  funct3 for BRANCH; 010 = none; 011 = unconditional jump
alu_op  out  4  {funct3, bit30}; ADD = 0000
immediate  out  32  sign-extended immediate
illegal  out  1  undecodable instruction
md_en  out  1  M-extension op (see Optional Feature)
md_op  out  3  M-extension funct3
dec_count  out  COUNT_W  bundles handed to execute

Behaviour:
- Reset: out_valid=0, in_ready=1, both entries empty, dec_count=0. All bundle fields 0 except br_type=010.
- Latency: an instruction accepted in cycle N is presented at out_valid in cycle N+1 if the output entry is free.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Buffering: entries are output register plus skid register, both storing decoded bundles. in_ready is registered and equals !skid_full.
  - Input accepted while output is held: bundle goes to skid.
  - Output consumed: skid moves to output the same cycle.
  - Simultaneous accept and consume with skid empty: bundle goes straight to output.
  - Order is strictly FIFO.
- Output stability: fields stay stable while out_valid & !out_ready.
- flush: both entries empty next cycle, out_valid=0, in_ready=1. An input offered in the flush cycle is discarded. flush overrides every transfer.
- rst mid-stream: same as flush, plus dec_count cleared.
- dec_count: +1 per output transfer, wraps modulo 2^COUNT_W.
- Decode rules:
  - R: alu_op={f3,b30}, reg_wr=1, sel_A=0, sel_B=0.
  - I-ALU: bit30 used only for f3=101, else 0. sel_B=1, imm=I-type.
  - LOAD: alu_op=ADD, wb_sel=01.
  - STORE: reg_wr=0, mem_wr=1, imm=S-type.
  - BRANCH: sel_A=1, sel_B=1, ADD, br_type=f3, imm=B-type.
  - JAL: sel_A=1, imm=J-type, wb_sel=10, br_type=011.
  - JALR: sel_A=0, I-imm, wb_sel=10, br_type=011.
  - LUI: imm=U-type, wb_sel=11.
  - AUIPC: sel_A=1, U-imm, wb_sel=00.
  - Every field is assigned on every path; no latches.
- Illegal instructions:
  - Conditions: unknown opcode; R-type funct7 not 0000000/0100000; 0100000 with f3 not 000/101; shift-imm bad funct7; BRANCH f3 010/011.
  - Response: illegal=1, reg_wr=0, mem_wr=0, br_type=010. The bundle still flows and is counted.

Optional Feature:
- Macro: DECODE_RVM_EN.
- Defined: R-type with funct7=0000001 decodes as md_en=1, md_op=f3, reg_wr=1, wb_sel=00, not illegal.
- Undefined: md_en and md_op are tied 0, and funct7=0000001 is illegal.

Test Plan:
- rst then 0x00A00093 (addi x1,x0,10), out_ready=1 -> next cycle: out_valid=1, rd=1, alu_op=0000, immediate=0x0000000A, sel_B=1, reg_wr=1, illegal=0, dec_count=1 after transfer.
- 0xFE000EE3 (beq x0,x0,-4) -> br_type=000, sel_A=1, immediate=0xFFFFFFFC, reg_wr=0.
- 0x0020A423 (sw x2,8(x1)) -> mem_wr=1, reg_wr=0, rd_wr_mem=010, immediate=8.
- Backpressure: 3 back-to-back instructions with out_ready=0 for 3 cycles:
  - in_ready falls after 2 accepted.
  - Third is held by fetch.
  - On release, all 3 emerge in order, no loss or duplication.
- flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; dec_count unchanged; 0xFFFFFFFF then yields illegal=1, br_type=010.
- 0x022081B3 (mul x3,x1,x2) -> with DECODE_RVM_EN: md_en=1, md_op=000, illegal=0; without: illegal=1, md_en=0.
